// File: rtl/alu_op_responder.sv
// Responder for the term-evaluation ALU handshake: turns start pulses into a
// valid/ready request to a shared FP core and returns the result on a one-cycle strobe.
module alu_op_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mult_start,
    input  logic                  add_start,
    input  logic                  divide_start,
    input  logic                  exponent_start,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] mult_result,
    output logic [DATA_WIDTH-1:0] add_result,
    output logic [DATA_WIDTH-1:0] divide_result,
    output logic [DATA_WIDTH-1:0] exponent_result,
    output logic                  mult_data_ready,
    output logic                  add_data_ready,
    output logic                  divide_data_ready,
    output logic                  exponent_data_ready,
    output logic                  core_req_valid,
    output logic [1:0]            core_req_op,
    output logic [DATA_WIDTH-1:0] core_req_a,
    output logic [DATA_WIDTH-1:0] core_req_b,
    input  logic                  core_req_ready,
    input  logic                  core_rsp_valid,
    input  logic [DATA_WIDTH-1:0] core_rsp_data,
    output logic                  busy,
    output logic                  err_collision,
    output logic                  err_timeout
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_EXP  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [TIMER_W-1:0]      timer;
    logic [TIMER_W-1:0]      timer_next;
    logic [1:0]              op_next;
    logic [DATA_WIDTH-1:0]   a_next;
    logic [DATA_WIDTH-1:0]   b_next;
    logic [DATA_WIDTH-1:0]   ret_data;
    logic                    collide;
    logic                    timed_out;
    logic                    any_start;
    logic                    multi_start;
    logic                    ret_now;

    assign any_start   = add_start | mult_start | divide_start | exponent_start;
    assign multi_start = (add_start & (mult_start | divide_start | exponent_start)) |
                         (mult_start & (divide_start | exponent_start)) |
                         (divide_start & exponent_start);
    assign ret_now     = (state_next == RETURN);

    // The core_req_* outputs double as the latched op/operand storage.
    always_comb begin
        state_next = state;
        timer_next = timer;
        op_next    = core_req_op;
        a_next     = core_req_a;
        b_next     = core_req_b;
        ret_data   = '0;
        collide    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (any_start) begin
                    state_next = ISSUE;
                    a_next     = operand_a;
                    b_next     = operand_b;
                    collide    = multi_start;
                    if (add_start)         op_next = OP_ADD;
                    else if (mult_start)   op_next = OP_MULT;
                    else if (divide_start) op_next = OP_DIV;
                    else                   op_next = OP_EXP;
                end
            end
            ISSUE: begin
                collide = any_start;
                if (core_req_ready) begin
                    state_next = WAIT_RSP;
                    timer_next = '0;
                end
            end
            WAIT_RSP: begin
                collide    = any_start;
                timer_next = timer + TIMER_W'(1);
                // A response on the last allowed cycle takes precedence over the timeout.
                if (core_rsp_valid) begin
                    ret_data   = core_rsp_data;
                    state_next = RETURN;
                end else if (timer == TIMER_LAST) begin
                    timed_out  = 1'b1;
                    state_next = RETURN;
                end
            end
            RETURN: begin
                collide    = any_start;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is a flop so the accumulator sees glitch-free, zero-when-idle buses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            timer               <= '0;
            core_req_op         <= OP_EXP;
            core_req_a          <= '0;
            core_req_b          <= '0;
            core_req_valid      <= 1'b0;
            busy                <= 1'b0;
            err_collision       <= 1'b0;
            err_timeout         <= 1'b0;
            mult_data_ready     <= 1'b0;
            add_data_ready      <= 1'b0;
            divide_data_ready   <= 1'b0;
            exponent_data_ready <= 1'b0;
            mult_result         <= '0;
            add_result          <= '0;
            divide_result       <= '0;
            exponent_result     <= '0;
        end else begin
            state               <= state_next;
            timer               <= timer_next;
            core_req_op         <= op_next;
            core_req_a          <= a_next;
            core_req_b          <= b_next;
            core_req_valid      <= (state_next == ISSUE);
            busy                <= (state_next != IDLE);
            err_collision       <= collide;
            err_timeout         <= timed_out;
            mult_data_ready     <= ret_now && (op_next == OP_MULT);
            add_data_ready      <= ret_now && (op_next == OP_ADD);
            divide_data_ready   <= ret_now && (op_next == OP_DIV);
            exponent_data_ready <= ret_now && (op_next == OP_EXP);
            mult_result         <= (ret_now && (op_next == OP_MULT)) ? ret_data : '0;
            add_result          <= (ret_now && (op_next == OP_ADD))  ? ret_data : '0;
            divide_result       <= (ret_now && (op_next == OP_DIV))  ? ret_data : '0;
            exponent_result     <= (ret_now && (op_next == OP_EXP))  ? ret_data : '0;
        end
    end

endmodule
